// File: rtl/factor_check_seq.sv
// factor_check_seq: sequential factorization checker.
// Multiplies a captured factor pair with a shift-add multiplier (one multiplier
// bit per cycle). It then reports whether the product equals the captured target.
// A saturating counter tracks how many passing results were delivered.
// Optional feature macro: FACTOR_NONTRIVIAL_EN. When it is defined, factors equal
// to 0 or 1 are also rejected.
module factor_check_seq #(
  parameter int W  = 4,
  parameter int CW = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     i1,
  input  logic [W-1:0]     i2,
  input  logic [2*W-1:0]   a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ok,
  output logic [2*W-1:0]   product,
  output logic [CW-1:0]    pass_cnt
);

  localparam int SW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [SW-1:0]   step_q, step_d;
  logic [W-1:0]    i1_q, i2_q;
  logic [2*W-1:0]  a_q;
  logic            ok_q, ok_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            load;
  logic [2*W-1:0]  addend;
`ifdef FACTOR_NONTRIVIAL_EN
  logic            nontrivial;
`endif

  // State, datapath and counter registers; reset discards any in-flight candidate
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      step_q  <= '0;
      i1_q    <= '0;
      i2_q    <= '0;
      a_q     <= '0;
      ok_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      step_q  <= step_d;
      ok_q    <= ok_d;
      cnt_q   <= cnt_d;
      if (load) begin
        i1_q <= i1;
        i2_q <= i2;
        a_q  <= a;
      end
    end
  end

  // Next-state logic: one partial product per MUL cycle; ok is decided on the last step
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    step_d  = step_q;
    ok_d    = ok_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    addend  = i1_q[step_q] ? ({{W{1'b0}}, i2_q} << step_q) : '0;
`ifdef FACTOR_NONTRIVIAL_EN
    nontrivial = (i1_q != W'(0)) && (i1_q != W'(1)) &&
                 (i2_q != W'(0)) && (i2_q != W'(1));
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          acc_d   = '0;
          step_d  = '0;
          ok_d    = 1'b0;
          state_d = MUL;
        end
      end
      MUL: begin
        acc_d  = acc_q + addend;
        step_d = step_q + SW'(1);
        if (step_q == SW'(W - 1)) begin
          state_d = DONE;
`ifdef FACTOR_NONTRIVIAL_EN
          ok_d = (acc_d == a_q) && nontrivial;
`else
          ok_d = (acc_d == a_q);
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          ok_d    = 1'b0;
          if (ok_q && (cnt_q != {CW{1'b1}})) begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign product   = acc_q;
  assign ok        = ok_q;
  assign pass_cnt  = cnt_q;

endmodule

// File: tb/tb_factor_check_seq.sv
// tb_factor_check_seq: directed bench for factor_check_seq with a transaction-level
// reference model. It is built with CW=2 so that counter saturation is reachable.
// It honours FACTOR_NONTRIVIAL_EN in the same way as the design.
module tb_factor_check_seq;

  localparam int W  = 4;
  localparam int CW = 2;
  localparam int MAXC = (1 << CW) - 1;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    i1;
  logic [W-1:0]    i2;
  logic [2*W-1:0]  a;
  logic            out_valid;
  logic            out_ready;
  logic            ok;
  logic [2*W-1:0]  product;
  logic [CW-1:0]   pass_cnt;

  int total = 0;
  int bad   = 0;
  bit started = 0;

  // Reference model state: one outstanding candidate at most
  bit pending;
  int cyc;
  int valid_from;
  int m_prod;
  int m_ok;
  int m_cnt;

  factor_check_seq #(.W(W), .CW(CW)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .i1(i1),
    .i2(i2),
    .a(a),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ok(ok),
    .product(product),
    .pass_cnt(pass_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s got=%0d want=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int modelOk(input int x, input int y, input int t);
    int r;
    r = (x * y == t) ? 1 : 0;
`ifdef FACTOR_NONTRIVIAL_EN
    if (x < 2 || y < 2) r = 0;
`endif
    return r;
  endfunction

  // Model: accept on ready&valid, result visible W cycles later, count on delivery
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pending = 0;
      cyc = 0;
      valid_from = 0;
      m_prod = 0;
      m_ok = 0;
      m_cnt = 0;
    end else begin
      bit ov;
      ov = pending && (cyc >= valid_from);
      cyc++;
      if (ov && out_ready) begin
        pending = 0;
        if (m_ok == 1 && m_cnt < MAXC) m_cnt++;
      end else if (!pending && in_valid) begin
        pending = 1;
        valid_from = cyc + W;
        m_prod = int'(i1) * int'(i2);
        m_ok = modelOk(int'(i1), int'(i2), int'(a));
      end
    end
  end

  // Cycle-by-cycle comparison of the DUT against the model
  always @(negedge clk) begin
    if (started && !rst) begin
      bit exp_ov;
      exp_ov = pending && (cyc >= valid_from);
      checkOutput("cyc_out_valid", int'(out_valid), int'(exp_ov));
      checkOutput("cyc_in_ready", int'(in_ready), pending ? 0 : 1);
      checkOutput("cyc_pass_cnt", int'(pass_cnt), m_cnt);
      if (exp_ov) begin
        checkOutput("cyc_product", int'(product), m_prod);
        checkOutput("cyc_ok", int'(ok), m_ok);
      end
    end
  end

  task automatic applyStimulus(input int x, input int y, input int t);
    in_valid = 1'b1;
    i1 = W'(x);
    i2 = W'(y);
    a  = (2*W)'(t);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic waitResult(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_latency"}, n, W);
  endtask

  task automatic runCheck(input string tag, input int x, input int y, input int t,
                          input int want_prod, input int want_ok, input int want_cnt);
    applyStimulus(x, y, t);
    waitResult(tag);
    checkOutput({tag, "_product"}, int'(product), want_prod);
    checkOutput({tag, "_ok"}, int'(ok), want_ok);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, "_in_ready_after"}, int'(in_ready), 1);
    checkOutput({tag, "_pass_cnt"}, int'(pass_cnt), want_cnt);
  endtask

  int sat_x[5]   = '{2, 3, 5, 4, 7};
  int sat_y[5]   = '{3, 3, 2, 4, 2};
  int sat_cnt[5] = '{1, 2, 3, 3, 3};

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    i1 = '0;
    i2 = '0;
    a = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_out_valid", int'(out_valid), 0);
    checkOutput("reset_ok", int'(ok), 0);
    checkOutput("reset_product", int'(product), 0);
    checkOutput("reset_pass_cnt", int'(pass_cnt), 0);
    rst = 1'b0;
    started = 1;
    @(negedge clk);
    checkOutput("idle_in_ready", int'(in_ready), 1);

    runCheck("basic", 3, 5, 15, 15, 1, 1);
    runCheck("full", 15, 15, 225, 225, 1, 2);
    runCheck("full_bad", 15, 15, 224, 225, 0, 2);
`ifdef FACTOR_NONTRIVIAL_EN
    runCheck("trivial", 1, 15, 15, 15, 0, 2);
`else
    runCheck("trivial", 1, 15, 15, 15, 1, 3);
`endif

    // Backpressure: result must hold while inputs churn
    applyStimulus(6, 7, 42);
    waitResult("bp");
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      i1 = W'($urandom_range(0, 15));
      @(negedge clk);
      checkOutput("bp_product", int'(product), 42);
      checkOutput("bp_ok", int'(ok), 1);
      checkOutput("bp_in_ready", int'(in_ready), 0);
      checkOutput("bp_out_valid", int'(out_valid), 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checkOutput("bp_in_ready_hs", int'(in_ready), 0);
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("bp_in_ready_next", int'(in_ready), 1);
    checkOutput("bp_pass_cnt", int'(pass_cnt), 3);

    // Reset two cycles into the multiply
    applyStimulus(5, 3, 15);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_mid_out_valid", int'(out_valid), 0);
    checkOutput("rst_mid_product", int'(product), 0);
    checkOutput("rst_mid_ok", int'(ok), 0);
    checkOutput("rst_mid_pass_cnt", int'(pass_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_in_ready", int'(in_ready), 1);
    runCheck("after_rst", 2, 3, 6, 6, 1, 1);

    // Saturation of the 2-bit pass counter
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      runCheck("sat", sat_x[k], sat_y[k], sat_x[k] * sat_y[k],
               sat_x[k] * sat_y[k], 1, sat_cnt[k]);
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
